// File: rtl/tc_mem_pkg.sv
// Shared types and default geometry for the tc RAM arbiter slice.
package tc_mem_pkg;
   localparam int AW_DEF        = 8;
   localparam int DW_DEF        = 8;
   localparam int CLEAR_VAL_DEF = 0;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;
endpackage

// File: rtl/tc_rr_arb2.sv
// Two-way round-robin grant logic; prio names the port that wins a tie.
module tc_rr_arb2
   import tc_mem_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   logic prio_r;
   logic gnt0_s;
   logic gnt1_s;

   // Grant decode: a lone requester always wins, a tie goes to prio.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (rst || !en) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else if (req0 && req1) begin
         gnt0_s = ~prio_r;
         gnt1_s = prio_r;
      end else begin
         gnt0_s = req0;
         gnt1_s = req1;
      end
   end

   // Priority flips away from whichever port was just served.
   always_ff @(posedge clk) begin
      if (rst) begin
         prio_r <= 1'b0;
      end else if (gnt0_s) begin
         prio_r <= 1'b1;
      end else if (gnt1_s) begin
         prio_r <= 1'b0;
      end else begin
         prio_r <= prio_r;
      end
   end

   assign gnt0 = gnt0_s;
   assign gnt1 = gnt1_s;

endmodule

// File: rtl/tc_ram_arbiter.sv
// Shares one single-port RAM between two requesters and adds a zero-fill sweep
// that walks every word without touching the macro's own reset.
module tc_ram_arbiter
   import tc_mem_pkg::*;
#(
   parameter int            AW        = AW_DEF,
   parameter int            DW        = DW_DEF,
   parameter logic [DW-1:0] CLEAR_VAL = DW'(CLEAR_VAL_DEF)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_req,
   output logic          clear_busy,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          ram_load,
   output logic          ram_save,
   output logic [AW-1:0] ram_address,
   output logic [DW-1:0] ram_in,
   input  logic [DW-1:0] ram_out
);

   localparam logic [AW-1:0] CNT_MAX = {AW{1'b1}};

   state_t        state_r;
   logic [AW-1:0] clr_cnt_r;
   logic          rvalid0_r;
   logic          rvalid1_r;
   logic          gnt0_s;
   logic          gnt1_s;
   logic          arb_en_s;
   logic          load_s;
   logic          save_s;
   logic [AW-1:0] addr_s;
   logic [DW-1:0] din_s;

   assign arb_en_s = (state_r == ST_ARB);

   tc_rr_arb2 u_arb (
      .clk  (clk),
      .rst  (rst),
      .en   (arb_en_s),
      .req0 (req0),
      .req1 (req1),
      .gnt0 (gnt0_s),
      .gnt1 (gnt1_s)
   );

   // Sweep sequencer: clear_req is only honoured from ARB, so a re-pulse cannot stretch it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_ARB;
         clr_cnt_r <= '0;
      end else begin
         case (state_r)
            ST_ARB: begin
               clr_cnt_r <= '0;
               state_r   <= clear_req ? ST_CLEAR : ST_ARB;
            end
            ST_CLEAR: begin
               if (clr_cnt_r == CNT_MAX) begin
                  clr_cnt_r <= '0;
                  state_r   <= ST_ARB;
               end else begin
                  clr_cnt_r <= clr_cnt_r + AW'(1);
                  state_r   <= ST_CLEAR;
               end
            end
            default: begin
               clr_cnt_r <= '0;
               state_r   <= ST_ARB;
            end
         endcase
      end
   end

   // Read-valid pulses track the RAM's one-cycle registered read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid0_r <= 1'b0;
         rvalid1_r <= 1'b0;
      end else begin
         rvalid0_r <= gnt0_s & ~we0;
         rvalid1_r <= gnt1_s & ~we1;
      end
   end

   // RAM pin mux: the sweep owns the macro outright, otherwise the granted port does.
   always_comb begin
      load_s = 1'b0;
      save_s = 1'b0;
      addr_s = '0;
      din_s  = '0;
      if (rst) begin
         load_s = 1'b0;
         save_s = 1'b0;
      end else if (state_r == ST_CLEAR) begin
         save_s = 1'b1;
         addr_s = clr_cnt_r;
         din_s  = CLEAR_VAL;
      end else if (gnt0_s) begin
         save_s = we0;
         load_s = ~we0;
         addr_s = addr0;
         din_s  = wdata0;
      end else if (gnt1_s) begin
         save_s = we1;
         load_s = ~we1;
         addr_s = addr1;
         din_s  = wdata1;
      end else begin
         load_s = 1'b0;
         save_s = 1'b0;
      end
   end

   assign gnt0        = gnt0_s;
   assign gnt1        = gnt1_s;
   assign ram_load    = load_s;
   assign ram_save    = save_s;
   assign ram_address = addr_s;
   assign ram_in      = din_s;
   assign rvalid0     = rvalid0_r;
   assign rvalid1     = rvalid1_r;
   assign rdata0      = rvalid0_r ? ram_out : '0;
   assign rdata1      = rvalid1_r ? ram_out : '0;
   assign clear_busy  = (state_r == ST_CLEAR);

endmodule
